// File: rtl/rmw_long_latency_tbl.sv
// -----------------------------------------------------------------------------
// rmw_long_latency_tbl
//
// Purpose:
//   Table responder at the far end of the RMW engine's lookup interface.
//   Holds 2**ID_W words. It accepts one read per cycle and answers each read
//   exactly LATENCY cycles later with the word and the request's tag. It also
//   applies writebacks. After reset, an internal init sequence clears every
//   entry, one entry per cycle. Traffic is accepted only once tbl_init_done_r
//   is high.
//
// Ports:
//   clk                in   1      clock
//   rst                in   1      asynchronous, active-low reset
//   tbl_wr_r           in   1      write strobe
//   tbl_wr_id_r        in   ID_W   write index
//   tbl_wr_word_r      in   W      write data
//   tbl_rd_r           in   1      read strobe
//   tbl_rd_id_r        in   ID_W   read index
//   tbl_rd_itag_r      in   TAG_W  read issue tag
//   tbl_rd_word_vld_r  out  1      read response valid (one cycle per response)
//   tbl_rd_word_r      out  W      read response data (holds when not valid)
//   tbl_rd_ctag_r      out  TAG_W  completion tag (itag of the request)
//   tbl_init_done_r    out  1      table cleared, accepting traffic
//   tbl_err_r          out  1      sticky: rd/wr seen while not ready
//
// Parameters:
//   W        data word width
//   ID_W     id width, depth ENTRIES = 2**ID_W
//   TAG_W    tag width
//   LATENCY  request-to-response cycles, legal range 1..16
// -----------------------------------------------------------------------------
module rmw_long_latency_tbl #(
    parameter int W       = 32,
    parameter int ID_W    = 4,
    parameter int TAG_W   = 4,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tbl_wr_r,
    input  logic [ID_W-1:0]  tbl_wr_id_r,
    input  logic [W-1:0]     tbl_wr_word_r,
    input  logic             tbl_rd_r,
    input  logic [ID_W-1:0]  tbl_rd_id_r,
    input  logic [TAG_W-1:0] tbl_rd_itag_r,
    output logic             tbl_rd_word_vld_r,
    output logic [W-1:0]     tbl_rd_word_r,
    output logic [TAG_W-1:0] tbl_rd_ctag_r,
    output logic             tbl_init_done_r,
    output logic             tbl_err_r
);

    localparam int              ENTRIES  = 1 << ID_W;
    localparam logic [ID_W-1:0] CNT_LAST = ID_W'(ENTRIES - 1);

    // -------------------------------------------------------------------------
    // Init / run FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ID_W-1:0] init_cnt_q;
    logic [ID_W-1:0] init_cnt_d;
    logic            init_active;
    logic            init_done_q;
    logic            init_done_d;
    logic            err_q;
    logic            err_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: INIT walks every entry once, then RUN until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs. init_done is registered from the state, so it rises one
    // cycle after the last entry has been cleared.
    always_comb begin
        init_active = (state_q == ST_INIT);
        init_done_d = (state_q == ST_RUN);
    end

    // -------------------------------------------------------------------------
    // Request acceptance
    // -------------------------------------------------------------------------
    // Accepting is keyed off the registered done flag rather than the state.
    // This way a request is never accepted while tbl_init_done_r still reads 0.
    logic rd_accept;
    logic wr_accept;

    always_comb begin
        rd_accept  = tbl_rd_r & init_done_q;
        wr_accept  = tbl_wr_r & init_done_q;
        err_d      = err_q | ((tbl_rd_r | tbl_wr_r) & ~init_done_q);
        init_cnt_d = init_active ? (init_cnt_q + ID_W'(1)) : init_cnt_q;
    end

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    // The write port is shared between the init sweep and writebacks. The
    // sweep only runs while no traffic is accepted, so the two never collide.
    logic [W-1:0]    mem_q [ENTRIES];
    logic            mem_we_d;
    logic [ID_W-1:0] mem_waddr_d;
    logic [W-1:0]    mem_wdata_d;
    logic [W-1:0]    rd_raw_q;

    always_comb begin
        mem_we_d    = init_active | wr_accept;
        mem_waddr_d = init_active ? init_cnt_q : tbl_wr_id_r;
        mem_wdata_d = init_active ? '0 : tbl_wr_word_r;
    end

    // Registered read in the same block as the write. Because of non-blocking
    // semantics, a same-cycle read of the written id returns the old value.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
        rd_raw_q <= mem_q[tbl_rd_id_r];
    end

    // -------------------------------------------------------------------------
    // Response pipeline
    // -------------------------------------------------------------------------
    // vld_q[0] / tag_q[0] are loaded on the request edge, next to rd_raw_q.
    // vld_q[LATENCY] / tag_q[LATENCY] are the output registers.
    // The word chain starts at rd_raw_q. For that reason word_q[j] lines up
    // with vld_q[j+1], and word_q[LATENCY-1] is the output word.
    logic [LATENCY:0] vld_q;
    logic [LATENCY:0] vld_d;
    logic [TAG_W-1:0] tag_q  [LATENCY+1];
    logic [TAG_W-1:0] tag_d  [LATENCY+1];
    logic [W-1:0]     word_q [LATENCY];
    logic [W-1:0]     word_d [LATENCY];

    always_comb begin
        vld_d[0]  = rd_accept;
        tag_d[0]  = tbl_rd_itag_r;
        word_d[0] = rd_raw_q;
        for (int j = 1; j <= LATENCY; j++) begin
            vld_d[j] = vld_q[j-1];
            tag_d[j] = tag_q[j-1];
        end
        for (int j = 1; j < LATENCY; j++) begin
            word_d[j] = word_q[j-1];
        end
        // Output word and tag only move when a response lands. Otherwise
        // they keep showing the last response.
        if (!vld_q[LATENCY-1]) begin
            tag_d[LATENCY]    = tag_q[LATENCY];
            word_d[LATENCY-1] = word_q[LATENCY-1];
        end
    end

    // A reset clears every valid, so in-flight reads are dropped silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            vld_q       <= '0;
            for (int j = 0; j <= LATENCY; j++) begin
                tag_q[j] <= '0;
            end
            for (int j = 0; j < LATENCY; j++) begin
                word_q[j] <= '0;
            end
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
            for (int j = 0; j <= LATENCY; j++) begin
                tag_q[j] <= tag_d[j];
            end
            for (int j = 0; j < LATENCY; j++) begin
                word_q[j] <= word_d[j];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tbl_rd_word_vld_r = vld_q[LATENCY];
    assign tbl_rd_ctag_r     = tag_q[LATENCY];
    assign tbl_rd_word_r     = word_q[LATENCY-1];
    assign tbl_init_done_r   = init_done_q;
    assign tbl_err_r         = err_q;

endmodule

// File: tb/tb_rmw_long_latency_tbl.sv
// -----------------------------------------------------------------------------
// tb_rmw_long_latency_tbl
//
// Directed and random traffic against rmw_long_latency_tbl.
// The reference model keeps a plain array for the table contents and a queue
// of expected responses. Each queue entry is stamped with the edge index on
// which its response must appear.
// -----------------------------------------------------------------------------
module tb_rmw_long_latency_tbl;

    localparam int W       = 32;
    localparam int ID_W    = 4;
    localparam int TAG_W   = 4;
    localparam int LATENCY = 4;
    localparam int ENTRIES = 1 << ID_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             tbl_wr_r;
    logic [ID_W-1:0]  tbl_wr_id_r;
    logic [W-1:0]     tbl_wr_word_r;
    logic             tbl_rd_r;
    logic [ID_W-1:0]  tbl_rd_id_r;
    logic [TAG_W-1:0] tbl_rd_itag_r;
    logic             tbl_rd_word_vld_r;
    logic [W-1:0]     tbl_rd_word_r;
    logic [TAG_W-1:0] tbl_rd_ctag_r;
    logic             tbl_init_done_r;
    logic             tbl_err_r;

    rmw_long_latency_tbl #(
        .W       (W),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tbl_wr_r          (tbl_wr_r),
        .tbl_wr_id_r       (tbl_wr_id_r),
        .tbl_wr_word_r     (tbl_wr_word_r),
        .tbl_rd_r          (tbl_rd_r),
        .tbl_rd_id_r       (tbl_rd_id_r),
        .tbl_rd_itag_r     (tbl_rd_itag_r),
        .tbl_rd_word_vld_r (tbl_rd_word_vld_r),
        .tbl_rd_word_r     (tbl_rd_word_r),
        .tbl_rd_ctag_r     (tbl_rd_ctag_r),
        .tbl_init_done_r   (tbl_init_done_r),
        .tbl_err_r         (tbl_err_r)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int               due;
        logic [W-1:0]     word;
        logic [TAG_W-1:0] tag;
    } resp_t;

    resp_t            exp_q [$];
    logic [W-1:0]     model_mem [ENTRIES];
    logic             model_done;
    logic             model_err;
    logic [W-1:0]     last_word;
    logic [TAG_W-1:0] last_tag;
    int               edge_cnt;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        tbl_wr_r      = 1'b0;
        tbl_wr_id_r   = '0;
        tbl_wr_word_r = '0;
        tbl_rd_r      = 1'b0;
        tbl_rd_id_r   = '0;
        tbl_rd_itag_r = '0;
    endtask

    // Reset asserted away from any clock edge. Outputs must drop at once.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        chk("rst_vld",  {31'b0, tbl_rd_word_vld_r}, 32'd0);
        chk("rst_word", tbl_rd_word_r, 32'd0);
        chk("rst_ctag", {28'b0, tbl_rd_ctag_r}, 32'd0);
        chk("rst_done", {31'b0, tbl_init_done_r}, 32'd0);
        chk("rst_err",  {31'b0, tbl_err_r}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) model_mem[i] = '0;
        model_done = 1'b0;
        model_err  = 1'b0;
        last_word  = '0;
        last_tag   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        edge_cnt = 0;
    endtask

    // One clock edge. The model samples the same inputs as the DUT, then the
    // outputs are checked 1 time unit after the edge.
    task automatic step();
        int e;
        @(posedge clk);
        e = edge_cnt;
        edge_cnt++;
        if ((tbl_rd_r || tbl_wr_r) && !model_done) model_err = 1'b1;
        if (model_done && tbl_rd_r) begin
            resp_t r;
            r.due  = e + LATENCY;
            r.word = model_mem[tbl_rd_id_r];
            r.tag  = tbl_rd_itag_r;
            exp_q.push_back(r);
        end
        if (model_done && tbl_wr_r) model_mem[tbl_wr_id_r] = tbl_wr_word_r;
        model_done = (e >= ENTRIES);
        #1;
        chk("init_done", {31'b0, tbl_init_done_r}, {31'b0, model_done});
        chk("err", {31'b0, tbl_err_r}, {31'b0, model_err});
        if (exp_q.size() > 0 && exp_q[0].due == e) begin
            chk("rsp_vld", {31'b0, tbl_rd_word_vld_r}, 32'd1);
            chk("rsp_word", tbl_rd_word_r, exp_q[0].word);
            chk("rsp_ctag", {28'b0, tbl_rd_ctag_r}, {28'b0, exp_q[0].tag});
            last_word = exp_q[0].word;
            last_tag  = exp_q[0].tag;
            void'(exp_q.pop_front());
        end else begin
            chk("idle_vld", {31'b0, tbl_rd_word_vld_r}, 32'd0);
            chk("hold_word", tbl_rd_word_r, last_word);
            chk("hold_ctag", {28'b0, tbl_rd_ctag_r}, {28'b0, last_tag});
        end
    endtask

    task automatic op(input logic rd, input logic [ID_W-1:0] rid, input logic [TAG_W-1:0] itag,
                      input logic wr, input logic [ID_W-1:0] wid, input logic [W-1:0] wword);
        tbl_rd_r      = rd;
        tbl_rd_id_r   = rid;
        tbl_rd_itag_r = itag;
        tbl_wr_r      = wr;
        tbl_wr_id_r   = wid;
        tbl_wr_word_r = wword;
        step();
        idle_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;

        // 1: reset, init sweep, all entries read back as zero
        apply_reset();
        idle(ENTRIES + 2);
        for (int i = 0; i < ENTRIES; i++) op(1'b1, ID_W'(i), TAG_W'(i), 1'b0, '0, '0);
        idle(LATENCY + 2);
        chk("drain_1", exp_q.size(), 32'd0);

        // 2: write then read the same id on the next cycle
        op(1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF);
        op(1'b1, 4'd3, 4'd5, 1'b0, '0, '0);
        idle(LATENCY + 2);

        // 3: same-cycle read and write of the same id return the old value
        op(1'b0, '0, '0, 1'b1, 4'd7, 32'h22);
        op(1'b1, 4'd7, 4'd1, 1'b1, 4'd7, 32'h11);
        op(1'b1, 4'd7, 4'd2, 1'b0, '0, '0);
        idle(LATENCY + 2);
        chk("drain_3", exp_q.size(), 32'd0);

        // Random traffic, including duplicate tags in flight
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom), ID_W'($urandom), TAG_W'($urandom),
               1'($urandom), ID_W'($urandom), W'($urandom));
        end
        idle(LATENCY + 2);
        chk("drain_rand", exp_q.size(), 32'd0);

        // 5: traffic during init is dropped and sets the sticky error
        apply_reset();
        idle(3);
        op(1'b1, 4'd2, 4'd9, 1'b1, 4'd2, 32'h55);
        op(1'b0, '0, '0, 1'b1, 4'd4, 32'h66);
        idle(ENTRIES);
        op(1'b1, 4'd2, 4'd3, 1'b0, '0, '0);
        op(1'b1, 4'd4, 4'd4, 1'b0, '0, '0);
        idle(LATENCY + 2);
        chk("err_sticky", {31'b0, tbl_err_r}, 32'd1);

        // 6: reset with two reads in flight drops them and reclears the table
        op(1'b0, '0, '0, 1'b1, 4'd9, 32'hCAFE0001);
        op(1'b0, '0, '0, 1'b1, 4'd10, 32'hCAFE0002);
        op(1'b1, 4'd9, 4'd6, 1'b0, '0, '0);
        op(1'b1, 4'd10, 4'd7, 1'b0, '0, '0);
        apply_reset();
        idle(ENTRIES + 2);
        op(1'b1, 4'd9, 4'd8, 1'b0, '0, '0);
        op(1'b1, 4'd10, 4'd9, 1'b0, '0, '0);
        idle(LATENCY + 2);
        chk("drain_6", exp_q.size(), 32'd0);
        chk("err_after_rst", {31'b0, tbl_err_r}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
